// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU, with load-use / RAW hazard detection.
// Optional operand forwarding from MEM/WB is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
  localparam int unsigned DW  = 16,
  localparam int unsigned RW  = 3,
  localparam int unsigned OPW = 5,
  localparam int unsigned FNW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_opcode,
  input  logic [FNW-1:0] id_funct,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic           id_use_rt,
  input  logic [RW-1:0]  id_rd,
  input  logic           id_wr_en,
  input  logic           id_is_load,
  input  logic [DW-1:0]  id_a_data,
  input  logic [DW-1:0]  id_b_data,
  input  logic [DW-1:0]  id_imm,
  input  logic           exm_valid,
  input  logic           exm_wr_en,
  input  logic [RW-1:0]  exm_rd,
  input  logic [DW-1:0]  exm_result,
  input  logic           mwb_valid,
  input  logic           mwb_wr_en,
  input  logic [RW-1:0]  mwb_rd,
  input  logic [DW-1:0]  mwb_result,
  input  logic           flush,
  input  logic           ex_hold,
  output logic           ex_valid,
  output logic [OPW-1:0] ex_opcode,
  output logic [FNW-1:0] ex_funct,
  output logic [DW-1:0]  ex_ain,
  output logic [DW-1:0]  ex_bin,
  output logic [RW-1:0]  ex_rd,
  output logic           ex_wr_en,
  output logic           ex_is_load,
  output logic           stall_id
);

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic          use_rt_q;
  logic          load_use;
  logic          hazard;

  // True when a valid, writing producer targets a source the ID instruction reads.
  function automatic logic src_hit(input logic v, input logic we, input logic [RW-1:0] rd,
                                   input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                   input logic use_rt);
    return v & we & ((rd == rs) | (use_rt & (rd == rt)));
  endfunction

  assign load_use = id_valid & ex_is_load &
                    src_hit(ex_valid, ex_wr_en, ex_rd, id_rs, id_rt, id_use_rt);

`ifdef ALU_ISSUE_FWD_EN
  // Select the youngest in-flight producer of src; MEM wins over WB.
  function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] src, input logic [DW-1:0] base,
                                            input logic en,
                                            input logic m_v, input logic m_we, input logic [RW-1:0] m_rd,
                                            input logic [DW-1:0] m_res,
                                            input logic w_v, input logic w_we, input logic [RW-1:0] w_rd,
                                            input logic [DW-1:0] w_res);
    if (en && m_v && m_we && (m_rd == src)) return m_res;
    if (en && w_v && w_we && (w_rd == src)) return w_res;
    return base;
  endfunction

  assign hazard = load_use;
  assign ex_ain = fwd_sel(rs_q, a_q, ex_valid, exm_valid, exm_wr_en, exm_rd, exm_result,
                          mwb_valid, mwb_wr_en, mwb_rd, mwb_result);
  assign ex_bin = fwd_sel(rt_q, b_q, ex_valid & use_rt_q, exm_valid, exm_wr_en, exm_rd, exm_result,
                          mwb_valid, mwb_wr_en, mwb_rd, mwb_result);
`else
  logic unused_fwd;

  // No bypass anywhere: any in-flight writer of a used source must drain first.
  assign hazard = load_use | (id_valid & (
                    src_hit(ex_valid, ex_wr_en, ex_rd, id_rs, id_rt, id_use_rt) |
                    src_hit(exm_valid, exm_wr_en, exm_rd, id_rs, id_rt, id_use_rt) |
                    src_hit(mwb_valid, mwb_wr_en, mwb_rd, id_rs, id_rt, id_use_rt)));
  assign ex_ain = a_q;
  assign ex_bin = b_q;
  assign unused_fwd = ^{exm_result, mwb_result, rs_q, rt_q, use_rt_q};
`endif

  assign stall_id = (hazard | ex_hold) & ~flush & rst_n;

  // Pipeline register: flush > hold > bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
      ex_rd      <= '0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      use_rt_q   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!ex_hold) begin
      if (stall_id) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid   <= id_valid;
        ex_opcode  <= id_opcode;
        ex_funct   <= id_funct;
        ex_rd      <= id_rd;
        ex_wr_en   <= id_wr_en;
        ex_is_load <= id_is_load;
        a_q        <= id_a_data;
        b_q        <= id_use_rt ? id_b_data : id_imm;
        rs_q       <= id_rs;
        rt_q       <= id_rt;
        use_rt_q   <= id_use_rt;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed hazard/forwarding steps, then
// randomized traffic against an instruction-level model (honours ALU_ISSUE_FWD_EN).
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rt, id_wr_en, id_is_load;
  logic [4:0]  id_opcode;
  logic [1:0]  id_funct;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_a_data, id_b_data, id_imm;
  logic        exm_valid, exm_wr_en, mwb_valid, mwb_wr_en;
  logic [2:0]  exm_rd, mwb_rd;
  logic [15:0] exm_result, mwb_result;
  logic        flush, ex_hold;
  logic        ex_valid, ex_wr_en, ex_is_load, stall_id;
  logic [4:0]  ex_opcode;
  logic [1:0]  ex_funct;
  logic [2:0]  ex_rd;
  logic [15:0] ex_ain, ex_bin;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .id_a_data(id_a_data), .id_b_data(id_b_data), .id_imm(id_imm),
    .exm_valid(exm_valid), .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_valid(mwb_valid), .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_ain(ex_ain), .ex_bin(ex_bin), .ex_rd(ex_rd),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .stall_id(stall_id)
  );

  // The instruction the model believes sits in EX.
  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic [1:0]  fn;
    logic [2:0]  rd;
    logic        we;
    logic        ld;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        usert;
  } ex_t;

  ex_t m;

  function automatic bit writes(input logic v, input logic we, input logic [2:0] rd, input logic [2:0] r);
    return v && we && (rd == r);
  endfunction

  function automatic bit reads_from(input logic v, input logic we, input logic [2:0] rd);
    return writes(v, we, rd, id_rs) || (id_use_rt && writes(v, we, rd, id_rt));
  endfunction

  function automatic bit exp_stall();
    bit lu, raw;
    if (!rst_n || flush) return 1'b0;
    if (ex_hold) return 1'b1;
    if (!id_valid) return 1'b0;
    lu  = m.ld && reads_from(m.v, m.we, m.rd);
    raw = reads_from(m.v, m.we, m.rd) || reads_from(exm_valid, exm_wr_en, exm_rd) ||
          reads_from(mwb_valid, mwb_wr_en, mwb_rd);
    return FWD ? lu : (lu || raw);
  endfunction

  function automatic logic [15:0] operand(input logic [2:0] src, input logic [15:0] reg_val, input bit may_fwd);
    if (FWD && may_fwd && m.v) begin
      if (writes(exm_valid, exm_wr_en, exm_rd, src)) return exm_result;
      if (writes(mwb_valid, mwb_wr_en, mwb_rd, src)) return mwb_result;
    end
    return reg_val;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".valid"},  16'(ex_valid),   16'(m.v));
    chk({tag, ".opcode"}, 16'(ex_opcode),  16'(m.op));
    chk({tag, ".funct"},  16'(ex_funct),   16'(m.fn));
    chk({tag, ".rd"},     16'(ex_rd),      16'(m.rd));
    chk({tag, ".wr_en"},  16'(ex_wr_en),   16'(m.we));
    chk({tag, ".load"},   16'(ex_is_load), 16'(m.ld));
    chk({tag, ".ain"},    ex_ain,          operand(m.rs, m.a, 1'b1));
    chk({tag, ".bin"},    ex_bin,          operand(m.rt, m.b, m.usert));
    chk({tag, ".stall"},  16'(stall_id),   16'(exp_stall()));
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    bit s;
    @(posedge clk);
    s = exp_stall();
    if (!rst_n) m = '0;
    else if (flush) m.v = 1'b0;
    else if (!ex_hold) begin
      if (s) m.v = 1'b0;
      else m = '{v: id_valid, op: id_opcode, fn: id_funct, rd: id_rd, we: id_wr_en, ld: id_is_load,
                 a: id_a_data, b: id_use_rt ? id_b_data : id_imm, rs: id_rs, rt: id_rt, usert: id_use_rt};
    end
    @(negedge clk);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                          input logic use_rt, input logic [2:0] rd, input logic we, input logic ld,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
    id_valid = v; id_opcode = op; id_funct = op[1:0]; id_rs = rs; id_rt = rt; id_use_rt = use_rt;
    id_rd = rd; id_wr_en = we; id_is_load = ld; id_a_data = a; id_b_data = b; id_imm = imm;
  endtask

  initial begin
    bit held;
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    drive_id(1'b0, 5'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    exm_valid = 1'b0; exm_wr_en = 1'b0; exm_rd = 3'd0; exm_result = 16'h0;
    mwb_valid = 1'b0; mwb_wr_en = 1'b0; mwb_rd = 3'd0; mwb_result = 16'h0;
    m = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    tick();

    // Load-use: LD r3 then a consumer of r3 -> one stall, one bubble, capture.
    drive_id(1'b1, 5'h08, 3'd1, 3'd2, 1'b0, 3'd3, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h0004);
    check_all("lu0"); tick();
    drive_id(1'b1, 5'h01, 3'd3, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 16'h3333, 16'h4444, 16'h0007);
    check_all("lu1"); chk("lu_stall", 16'(stall_id), 16'd1); tick();
    check_all("lu2"); chk("lu_bubble", 16'(ex_valid), 16'd0); chk("lu_release", 16'(stall_id), 16'd0); tick();
    check_all("lu3"); chk("lu_capture", 16'(ex_valid), 16'd1); chk("lu_ain", ex_ain, 16'h3333);
    chk("lu_imm_b", ex_bin, 16'h0007);

    // Flush beats hold.
    flush = 1'b1; ex_hold = 1'b1;
    check_all("fh0"); chk("fh_stall", 16'(stall_id), 16'd0); tick();
    flush = 1'b0; ex_hold = 1'b0; id_valid = 1'b0;
    check_all("fh1"); chk("fh_valid", 16'(ex_valid), 16'd0);

    // WB writer of r4 versus an rt=4 consumer, then an immediate-form instruction.
    mwb_valid = 1'b1; mwb_wr_en = 1'b1; mwb_rd = 3'd4; mwb_result = 16'h0C0C;
    drive_id(1'b1, 5'h02, 3'd0, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0303);
    check_all("wb0"); chk("wb_stall", 16'(stall_id), FWD ? 16'd0 : 16'd1); tick();
    check_all("wb1"); chk("wb_stall2", 16'(stall_id), FWD ? 16'd0 : 16'd1);
    mwb_valid = 1'b0;
    check_all("wb2"); chk("wb_retire", 16'(stall_id), 16'd0); tick();
    mwb_valid = 1'b1;
    drive_id(1'b1, 5'h03, 3'd1, 3'd4, 1'b0, 3'd2, 1'b1, 1'b0, 16'h0505, 16'h0606, 16'h0707);
    check_all("imm0"); chk("imm_nostall", 16'(stall_id), 16'd0); tick();
    mwb_valid = 1'b0;
    check_all("imm1"); chk("imm_b", ex_bin, 16'h0707);

`ifdef ALU_ISSUE_FWD_EN
    // Back-to-back dependence on r1 resolved from MEM.
    drive_id(1'b1, 5'h01, 3'd5, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 16'h0011, 16'h0022, 16'h0033);
    check_all("fw0"); tick();
    drive_id(1'b1, 5'h01, 3'd1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 16'hDEAD, 16'h0022, 16'h0033);
    check_all("fw1"); tick();
    id_valid = 1'b0; exm_valid = 1'b1; exm_wr_en = 1'b1; exm_rd = 3'd1; exm_result = 16'h1234;
    check_all("fw2"); chk("fwd_ain", ex_ain, 16'h1234);
    // Both MEM and WB write r2: MEM is younger and wins.
    exm_valid = 1'b0;
    drive_id(1'b1, 5'h04, 3'd6, 3'd2, 1'b1, 3'd0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 16'h0000);
    check_all("fw3"); tick();
    id_valid = 1'b0; exm_valid = 1'b1; exm_rd = 3'd2; exm_result = 16'h00AA;
    mwb_valid = 1'b1; mwb_wr_en = 1'b1; mwb_rd = 3'd2; mwb_result = 16'h0055;
    check_all("fw4"); chk("fwd_mem_pri", ex_bin, 16'h00AA);
    exm_valid = 1'b0; mwb_valid = 1'b0;
    tick();
`endif

    // Randomized traffic; decode holds its instruction whenever it was stalled.
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held)
        drive_id(1'($urandom_range(0, 3) != 0), 5'($urandom), 3'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 16'($urandom), 16'($urandom), 16'($urandom));
      exm_valid = 1'($urandom); exm_wr_en = 1'($urandom); exm_rd = 3'($urandom_range(0, 3));
      exm_result = 16'($urandom);
      mwb_valid = 1'($urandom); mwb_wr_en = 1'($urandom); mwb_rd = 3'($urandom_range(0, 3));
      mwb_result = 16'($urandom);
      flush   = 1'($urandom_range(0, 15) == 0);
      ex_hold = 1'($urandom_range(0, 7) == 0);
      check_all("rnd");
      held = exp_stall();
      if (i == 200) begin
        // Asynchronous reset between edges drops whatever was in flight.
        #2 rst_n = 1'b0;
        m = '0;
        check_all("mid_rst");
        chk("mid_rst_valid", 16'(ex_valid), 16'd0);
        chk("mid_rst_ain",   ex_ain,        16'h0000);
        chk("mid_rst_stall", 16'(stall_id), 16'd0);
        held = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
